// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents registered diff/borrow/overflow with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one operand bit processed per clock edge
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] d_sh;
  logic             br;
  logic             a_msb, b_msb;

  logic             load, step, last;
  logic             d, br_nxt;
  logic [WIDTH-1:0] d_sh_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy = (state == RUN);
    load = (state == IDLE) && start;
    step = (state == RUN);
    last = (state == RUN) && (cnt == LAST);
  end

  // One full-subtractor cell; d_sh_nxt holds the difference with the new bit at the MSB
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    d_sh_nxt = {d, d_sh};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      d_sh     <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        br    <= bin;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end else if (step) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        d_sh <= d_sh_nxt[WIDTH-1:1];
        br   <= br_nxt;
        cnt  <= cnt + 1'b1;
        if (last) begin
          diff     <= d_sh_nxt;
          borrow   <= br_nxt;
          // operands of different sign and result sign differs from the minuend
          overflow <= (a_msb != b_msb) && (d != a_msb);
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): scoreboard of expected
// results pushed at acceptance and compared on every done pulse.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic [W-1:0] diff;
  logic         borrow, overflow, busy, done;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   cyc    = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .borrow(borrow), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, xa} - {1'b0, xb} - {{W{1'b0}}, xbin};
    e.d   = full[W-1:0];
    e.br  = full[W];
    e.ov  = (xa[W-1] != xb[W-1]) && (e.d[W-1] != xa[W-1]);
    e.acc = 0;
    return e;
  endfunction

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow", 32'(borrow), 32'(e.br));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("latency", 32'(cyc - e.acc), 32'(W));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called at posedge+1 with DUT idle (or in its done cycle); returns at posedge+1 after acceptance.
  task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                          input bit expect_result);
    exp_t e;
    start = 1'b1; a = xa; b = xb; bin = xbin;
    @(posedge clk); #1;
    if (expect_result) begin
      e = model(xa, xb, xbin);
      e.acc = cyc;
      sb.push_back(e);
    end
    start = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xbin, input logic [W-1:0] ed, input logic eb, input logic eo);
    start_op(xa, xb, xbin, 1'b1);
    wait_done(W + 3);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
    chk({tag, "_overflow"}, 32'(overflow), 32'(eo));
    @(posedge clk); #1;
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_hold_diff"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int n0, last_done, off;
    rst = 1'b1; start = 1'b1; a = 4'hF; b = 4'h1; bin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    directed("c1", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);
    directed("c2", 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, 1'b0);
    directed("c3", 4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, 1'b1);
    directed("c4", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);

    // Case 5: second start while busy is ignored
    n0 = n_done;
    start_op(4'b1100, 4'b0011, 1'b0, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; a = 4'b0001; b = 4'b1110; bin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 6) @(posedge clk);
    #1;
    chk("c5_done_count", 32'(n_done - n0), 32'd1);
    chk("c5_diff", 32'(diff), 32'b1001);

    // Case 6: reset two cycles into RUN aborts
    n0 = n_done;
    start_op(4'b0110, 4'b0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("c6_busy", 32'(busy), 32'd0);
    chk("c6_done", 32'(done), 32'd0);
    chk("c6_diff", 32'(diff), 32'd0);
    rst = 1'b0;
    repeat (W + 6) @(posedge clk);
    #1;
    chk("c6_no_done", 32'(n_done - n0), 32'd0);

    // Case 7: start held high, new operands presented on each done cycle
    start_op(4'b0011, 4'b0101, 1'b0, 1'b1);
    start = 1'b1;
    last_done = -1;
    for (int k = 0; k < 6; k++) begin
      logic [W-1:0] na, nb;
      logic         nbin;
      exp_t         e;
      wait_done(W + 3);
      if (last_done >= 0) chk("c7_spacing", 32'(cyc - last_done), 32'(W + 1));
      last_done = cyc;
      na = 4'($urandom); nb = 4'($urandom); nbin = 1'($urandom);
      a = na; b = nb; bin = nbin;
      @(posedge clk); #1;
      e = model(na, nb, nbin);
      e.acc = cyc;
      sb.push_back(e);
      a = ~na; b = ~nb; bin = ~nbin;
    end
    start = 1'b0;
    wait_done(W + 3);
    chk("c7_spacing_last", 32'(cyc - last_done), 32'(W + 1));
    @(posedge clk); #1;

    // Case 8: all 512 combinations in a shuffled order
    off = int'($urandom_range(0, 511));
    for (int i = 0; i < 512; i++) begin
      int idx;
      idx = (i * 205 + off) % 512;
      start_op(idx[3:0], idx[7:4], idx[8], 1'b1);
      wait_done(W + 3);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend, sampled only on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend, sampled only on an accepted start.
REQ-007 The block SHALL have port bin, input, 1 bit, borrow-in, sampled only on an accepted start.
REQ-008 The block SHALL have port diff, output, WIDTH bits, the registered result of a - b - bin modulo 2^WIDTH.
REQ-009 The block SHALL have port borrow, output, 1 bit, registered borrow-out, 1 when unsigned a < b + bin.
REQ-010 The block SHALL have port overflow, output, 1 bit, registered two's-complement overflow of a - b - bin.
REQ-011 The block SHALL have port busy, output, 1 bit, high while a subtraction is in progress.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking that the result outputs have just updated.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN, plus a bit counter of ceil(log2(WIDTH+1)) bits.
REQ-014 In IDLE, start=1 at a rising edge SHALL be accepted: load a, b and bin into internal registers, clear the counter, go to RUN, and set busy=1.
REQ-015 In RUN, each edge SHALL process one bit LSB-first: d = a0 ^ b0 ^ br, with br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
REQ-016 In RUN, each edge SHALL shift the operand registers right by one and insert d at the MSB of the internal difference shift register.
REQ-017 The edge that processes bit WIDTH-1 SHALL perform all of the following.
- Load diff with the full difference.
- Load borrow with the final br.
- Load overflow as (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
- Set done=1 and busy=0, and return to IDLE.
REQ-018 Latency SHALL be exactly WIDTH edges from the accepting edge to the edge that raises done.
REQ-019 done SHALL be high for exactly one cycle per accepted start.
REQ-020 diff, borrow and overflow SHALL hold their values until the next completion or reset.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-022 start=1 during the cycle in which done=1 SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-023 Changes on a, b or bin after acceptance SHALL NOT affect the result.
REQ-024 For start held high continuously, a new operation SHALL begin on each IDLE edge, giving one result every WIDTH+1 cycles at most.
REQ-025 Arithmetic SHALL be exact for all 2^(2*WIDTH+1) input combinations, including the wrap-around of 0 - 1 to all ones.

Reset
REQ-026 rst=1 at a rising edge SHALL override all other inputs, including start on the same edge.
REQ-027 Reset SHALL force the following values.
- State to IDLE and counter to 0.
- diff to 0, borrow to 0 and overflow to 0.
- busy to 0 and done to 0.
REQ-028 Reset during RUN SHALL abort the operation with no done pulse; the first start after reset deasserts SHALL behave as from power-up.

Verification
REQ-029 The bench SHALL cover these directed scenarios, all with WIDTH=4.
- Case 1: a=0101, b=0011, bin=0, start for one cycle. Required: done exactly 4 edges later, diff=0010, borrow=0, overflow=0.
- Case 2: a=0000, b=0001, bin=0. Required: diff=1111, borrow=1, overflow=0 (wrap-around).
- Case 3: a=1010, b=0101, bin=1. Required: diff=0100, borrow=0, overflow=1 (-6 - 5 - 1 = -12).
- Case 4: a=0111, b=1000, bin=0. Required: diff=1111, borrow=1, overflow=1.
- Case 5: start pulsed again 2 cycles after acceptance, with different operands. Required: ignored; a single done carrying the first operation's result.
- Case 6: rst asserted 2 cycles into RUN. Required: next cycle busy=0, done=0, diff=0000; no done pulse appears afterwards.
- Case 7: start held high with a new operand on each done cycle. Required: consecutive done pulses 5 cycles apart with correct results.
- Case 8: exhaustive random check of all 512 input combinations against a - b - bin. Required: diff, borrow and overflow all match the expected values.
